msrv32_pc_ctrl: RTL and testbench



---
 rtl/msrv32_pc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_msrv32_pc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_pc_ctrl.sv
// PC register and fetch sequencer: issues valid/ready fetches and redirects on trap, MRET or taken branch.
// Optional: define MSRV32_PC_REDIRECT_CNT_EN to add redirect_cnt_out, a count of flush cycles.
module msrv32_pc_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic [31:0] iaddr_out,
  output logic        ivalid_out,
  input  logic        iready_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        instr_valid_out,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic        jalr_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] rs1_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_vec_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
`ifdef MSRV32_PC_REDIRECT_CNT_EN
  output logic [31:0] redirect_cnt_out,
`endif
  output logic        flush_out,
  output logic        misaligned_instr_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_KILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pc_q, pc_d;
  logic        iv_q, iv_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic        accept;
  logic        sample;
  logic        redir;
  logic        mis_ev;
  logic [31:0] redir_tgt;
  logic [31:0] br_tgt;

  assign ivalid_out           = (state_q == S_REQ) || (state_q == S_KILL);
  assign iaddr_out            = fa_q;
  assign pc_out               = pc_q;
  assign pc_plus_4_out        = pc_q + 32'd4;
  assign instr_valid_out      = iv_q;
  assign flush_out            = flush_q;
  assign misaligned_instr_out = mis_q;

  assign accept = ivalid_out && iready_in;
  assign sample = iv_q && !stall_in;
  assign br_tgt = jalr_in ? ((rs1_in + imm_in) & ~32'd1) : (pc_q + imm_in);

  // Redirect source selection; a misaligned branch target is reported, never fetched.
  always_comb begin
    redir     = 1'b0;
    mis_ev    = 1'b0;
    redir_tgt = br_tgt;
    if (sample) begin
      if (trap_taken_in) begin
        redir     = 1'b1;
        redir_tgt = trap_vec_in;
      end else if (mret_in) begin
        redir     = 1'b1;
        redir_tgt = epc_in;
      end else if (branch_taken_in) begin
        if (br_tgt[1]) mis_ev = 1'b1;
        else           redir  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    pc_d    = pc_q;
    iv_d    = iv_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (accept) begin
          fa_d = fa_q + 32'd4;
          if (stall_in) begin
            hold_d  = fa_q;
            state_d = S_HOLD;
          end else begin
            pc_d = fa_q;
            iv_d = 1'b1;
          end
        end else if (!stall_in) begin
          iv_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_in) begin
          pc_d    = hold_q;
          iv_d    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        // Old request must still complete; its data is dropped.
        if (accept) begin
          fa_d    = tgt_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mis_ev) begin
      flush_d = 1'b1;
      mis_d   = 1'b1;
      pc_d    = pc_q;
      iv_d    = 1'b0;
    end

    if (redir) begin
      flush_d = 1'b1;
      pc_d    = pc_q;
      iv_d    = 1'b0;
      if (state_q == S_REQ && !accept) begin
        tgt_d   = redir_tgt;
        state_d = S_KILL;
      end else begin
        fa_d    = redir_tgt;
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= S_IDLE;
      fa_q    <= BOOT_ADDR;
      tgt_q   <= BOOT_ADDR;
      hold_q  <= BOOT_ADDR;
      pc_q    <= BOOT_ADDR;
      iv_q    <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
      iv_q    <= iv_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

`ifdef MSRV32_PC_REDIRECT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_q) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) cnt_q <= 32'd0;
    else                      cnt_q <= cnt_d;
  end

  assign redirect_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_msrv32_pc_ctrl.sv
// Directed bench for msrv32_pc_ctrl with BOOT_ADDR=0x100; expected values are hand-derived.
module tb_msrv32_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        iv;
  logic        stall;
  logic        br;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        trap;
  logic [31:0] tvec;
  logic        mret;
  logic [31:0] epc;
  logic        flush;
  logic        mis;
`ifdef MSRV32_PC_REDIRECT_CNT_EN
  logic [31:0] rcnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msrv32_pc_ctrl #(.BOOT_ADDR(32'h100)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .iaddr_out(iaddr),
    .ivalid_out(ivalid),
    .iready_in(iready),
    .pc_out(pc),
    .pc_plus_4_out(pc4),
    .instr_valid_out(iv),
    .stall_in(stall),
    .branch_taken_in(br),
    .jalr_in(jalr),
    .imm_in(imm),
    .rs1_in(rs1),
    .trap_taken_in(trap),
    .trap_vec_in(tvec),
    .mret_in(mret),
    .epc_in(epc),
`ifdef MSRV32_PC_REDIRECT_CNT_EN
    .redirect_cnt_out(rcnt),
`endif
    .flush_out(flush),
    .misaligned_instr_out(mis)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    br = 0; jalr = 0; trap = 0; mret = 0;
  endtask

  initial begin
    rst = 1; iready = 1; stall = 0; br = 0; jalr = 0; imm = 0; rs1 = 0;
    trap = 0; tvec = 0; mret = 0; epc = 0;
    tick(); tick();
    chk("rst_ivalid", {31'd0, ivalid}, 0);
    chk("rst_iaddr", iaddr, 32'h100);
    chk("rst_pc", pc, 32'h100);
    chk("rst_pc4", pc4, 32'h104);
    chk("rst_iv", {31'd0, iv}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_mis", {31'd0, mis}, 0);
`ifdef MSRV32_PC_REDIRECT_CNT_EN
    chk("rst_cnt", rcnt, 0);
`endif

    // Sequential fetch
    rst = 0;
    tick();
    chk("req0_valid", {31'd0, ivalid}, 1);
    chk("req0_addr", iaddr, 32'h100);
    tick();
    chk("req1_addr", iaddr, 32'h104);
    chk("pc_first", pc, 32'h100);
    chk("iv_first", {31'd0, iv}, 1);
    tick();
    chk("req2_addr", iaddr, 32'h108);
    chk("pc_second", pc, 32'h104);
    chk("pc4_second", pc4, 32'h108);

    // Trap to 0x200, then backward branch to 0x1F0
    trap = 1; tvec = 32'h200;
    tick();
    clr_redir();
    chk("trap_flush", {31'd0, flush}, 1);
    chk("trap_iaddr", iaddr, 32'h200);
    chk("trap_iv", {31'd0, iv}, 0);
    tick();
    chk("trap_flush_end", {31'd0, flush}, 0);
    chk("pc_200", pc, 32'h200);
    br = 1; imm = 32'hFFFF_FFF0;
    tick();
    clr_redir();
    chk("br_flush", {31'd0, flush}, 1);
    chk("br_iaddr", iaddr, 32'h1F0);
    chk("br_iv", {31'd0, iv}, 0);
    chk("br_pc_kept", pc, 32'h200);
    iready = 0;
    tick();
    chk("br_wait_iv", {31'd0, iv}, 0);
    chk("br_wait_iaddr", iaddr, 32'h1F0);
    iready = 1;
    tick();
    chk("pc_1f0", pc, 32'h1F0);
    chk("iv_1f0", {31'd0, iv}, 1);

    // JALR clears bit 0; bit 1 set is misaligned
    br = 1; jalr = 1; rs1 = 32'h301; imm = 32'h4;
    tick();
    clr_redir();
    chk("jalr_iaddr", iaddr, 32'h304);
    tick();
    chk("pc_304", pc, 32'h304);
    br = 1; jalr = 1; rs1 = 32'h302; imm = 32'h4;
    tick();
    clr_redir();
    chk("mis_pulse", {31'd0, mis}, 1);
    chk("mis_flush", {31'd0, flush}, 1);
    chk("mis_iv", {31'd0, iv}, 0);
    chk("mis_iaddr", iaddr, 32'h30C);
    chk("mis_pc", pc, 32'h304);
    tick();
    chk("mis_end", {31'd0, mis}, 0);
    chk("mis_seq_iaddr", iaddr, 32'h310);
    chk("mis_seq_pc", pc, 32'h30C);

    // Redirect while 0x40 is pending and not accepted
    trap = 1; tvec = 32'h38;
    tick();
    clr_redir();
    tick(); tick();
    chk("pc_3c", pc, 32'h3C);
    chk("pend_iaddr", iaddr, 32'h40);
    iready = 0; br = 1; imm = 32'h100;
    tick();
    clr_redir();
    chk("kill_flush", {31'd0, flush}, 1);
    chk("kill_iaddr0", iaddr, 32'h40);
    chk("kill_ivalid", {31'd0, ivalid}, 1);
    tick();
    chk("kill_iaddr1", iaddr, 32'h40);
    chk("kill_flush_end", {31'd0, flush}, 0);
    tick();
    chk("kill_iaddr2", iaddr, 32'h40);
    iready = 1;
    tick();
    chk("kill_tgt", iaddr, 32'h13C);
    chk("kill_pc", pc, 32'h3C);
    chk("kill_iv", {31'd0, iv}, 0);
    tick();
    chk("pc_13c", pc, 32'h13C);

    // Priority: trap > mret > branch
    trap = 1; tvec = 32'h500; mret = 1; epc = 32'h600; br = 1; imm = 32'h20;
    tick();
    clr_redir();
    chk("prio_trap", iaddr, 32'h500);
    tick();
    chk("pc_500", pc, 32'h500);
    mret = 1; br = 1;
    tick();
    clr_redir();
    chk("prio_mret", iaddr, 32'h600);
    tick();
    chk("pc_600", pc, 32'h600);
`ifdef MSRV32_PC_REDIRECT_CNT_EN
    chk("cnt_8", rcnt, 8);
`endif

    // Stall during accept
    stall = 1;
    tick();
    chk("hold_ivalid", {31'd0, ivalid}, 0);
    chk("hold_pc", pc, 32'h600);
    tick();
    chk("hold_pc2", pc, 32'h600);
    stall = 0;
    tick();
    chk("hold_rel_pc", pc, 32'h604);
    chk("hold_rel_iv", {31'd0, iv}, 1);
    chk("hold_rel_iaddr", iaddr, 32'h608);
    tick();
    chk("pc_608", pc, 32'h608);

    // Reset in the middle of KILL
    iready = 0; br = 1; imm = 32'h10;
    tick();
    clr_redir();
    chk("kill2_ivalid", {31'd0, ivalid}, 1);
    rst = 1;
    tick();
    chk("rk_ivalid", {31'd0, ivalid}, 0);
    chk("rk_iaddr", iaddr, 32'h100);
    chk("rk_flush", {31'd0, flush}, 0);
`ifdef MSRV32_PC_REDIRECT_CNT_EN
    chk("rk_cnt", rcnt, 0);
`endif
    rst = 0; iready = 1;
    tick();
    chk("rk_req", iaddr, 32'h100);
    chk("rk_req_valid", {31'd0, ivalid}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
